ball_trail: RTL

//   Downstream of the ball motion stage, in the pixel clock domain. Once per sampling frame it

---
 rtl/ball_trail_if.sv | 35 +++
 rtl/ball_trail.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ball_trail_if.sv
`default_nettype none
// ============================================================================
// Module      : ball_trail_if
// Description : Bundles the per-pixel and per-frame signals exchanged between
//               the ball motion stage, the trail history block and the colour
//               mapper.
//               master : frame_tick, clear, BallX/BallY/BallS, DrawX/DrawY out;
//                        is_ball, is_trail, trail_age, count in
//               slave  : the reverse direction (used by ball_trail)
// Revision    : 1.0 - initial release
// ============================================================================
interface ball_trail_if;
  logic       frame_tick;  // one pulse per frame
  logic       clear;       // synchronous history flush
  logic [9:0] BallX;       // ball centre X
  logic [9:0] BallY;       // ball centre Y
  logic [9:0] BallS;       // ball half-size
  logic [9:0] DrawX;       // scan pixel X
  logic [9:0] DrawY;       // scan pixel Y
  logic       is_ball;     // pixel inside ball square
  logic       is_trail;    // pixel inside a valid trail square
  logic [3:0] trail_age;   // age of youngest hitting entry
  logic [4:0] count;       // number of valid history entries

  modport master (
    output frame_tick, clear, BallX, BallY, BallS, DrawX, DrawY,
    input  is_ball, is_trail, trail_age, count
  );

  modport slave (
    input  frame_tick, clear, BallX, BallY, BallS, DrawX, DrawY,
    output is_ball, is_trail, trail_age, count
  );
endinterface
`default_nettype wire

// File: rtl/ball_trail.sv
`default_nettype none
// ============================================================================
// Module      : ball_trail
// Description : Records the ball centre into a circular history buffer once
//               every SAMPLE_DIV frames (skipping samples where the ball has
//               not moved) and, for every scanned pixel, reports whether the
//               pixel is on the ball square or on any valid trail square.
//               Results are registered one clock after DrawX/DrawY.
// Ports       : Clk    - pixel/system clock
//               Reset  - asynchronous reset, active-high
//               bus    - ball_trail_if.slave: frame_tick, clear, BallX,
//                        BallY, BallS, DrawX, DrawY in; is_ball, is_trail,
//                        trail_age, count out
// Parameters  : DEPTH      history entries (2..16)
//               TRAIL_SIZE half-width of each trail square in pixels
//               SAMPLE_DIV frames per sample attempt (>=1)
// Revision    : 1.0 - initial release
// ============================================================================
module ball_trail #(
  parameter int DEPTH      = 8,
  parameter int TRAIL_SIZE = 2,
  parameter int SAMPLE_DIV = 2
) (
  input wire         Clk,
  input wire         Reset,
  ball_trail_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0]   LAST_DIV   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [4:0]         FULL_COUNT = 5'(DEPTH);
  localparam logic signed [10:0] TRAIL_LIM  = 11'(TRAIL_SIZE);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] r_wr_ptr;
  logic [DIV_W-1:0] r_div_cnt;
  logic [4:0]       r_count;
  logic [9:0]       r_buf_x [DEPTH];
  logic [9:0]       r_buf_y [DEPTH];

  logic             r_is_ball;
  logic             r_is_trail;
  logic [3:0]       r_trail_age;

  // --------------------------------------------------------------------------
  // Sampling / push decision
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] w_newest_ptr;
  logic             w_sample;
  logic             w_moved;
  logic             w_push;

  // Newest entry sits just behind the write pointer, wrapping at DEPTH-1.
  assign w_newest_ptr = (r_wr_ptr == '0) ? LAST_PTR : (r_wr_ptr - PTR_W'(1));

  // clear wins over a simultaneous frame_tick: the tick is simply dropped.
  assign w_sample = bus.frame_tick && !bus.clear && (r_div_cnt == LAST_DIV);

  assign w_moved  = (bus.BallX != r_buf_x[w_newest_ptr]) ||
                    (bus.BallY != r_buf_y[w_newest_ptr]);

  // With an empty history the newest slot holds stale data, so always push.
  assign w_push   = w_sample && ((r_count == 5'd0) || w_moved);

  // --------------------------------------------------------------------------
  // Control registers: divider, write pointer, occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr  <= '0;
      r_div_cnt <= '0;
      r_count   <= 5'd0;
    end else if (bus.clear) begin
      r_wr_ptr  <= '0;
      r_div_cnt <= '0;
      r_count   <= 5'd0;
    end else begin
      if (bus.frame_tick) begin
        r_div_cnt <= (r_div_cnt == LAST_DIV) ? '0 : (r_div_cnt + DIV_W'(1));
      end
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : (r_wr_ptr + PTR_W'(1));
        if (r_count != FULL_COUNT) begin
          r_count <= r_count + 5'd1;
        end
      end
    end
  end

  // History storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_buf_x[r_wr_ptr] <= bus.BallX;
      r_buf_y[r_wr_ptr] <= bus.BallY;
    end
  end

  // --------------------------------------------------------------------------
  // Ball hit test
  // Differences are taken in signed 11 bits so pixels near 0 and 1023 never
  // alias onto each other.
  // --------------------------------------------------------------------------
  logic signed [10:0] w_ball_dx;
  logic signed [10:0] w_ball_dy;
  logic signed [10:0] w_ball_lim;
  logic               w_hit_ball;

  assign w_ball_dx  = $signed({1'b0, bus.DrawX}) - $signed({1'b0, bus.BallX});
  assign w_ball_dy  = $signed({1'b0, bus.DrawY}) - $signed({1'b0, bus.BallY});
  assign w_ball_lim = $signed({1'b0, bus.BallS});

  assign w_hit_ball = (w_ball_dx <= w_ball_lim) && (w_ball_dx >= -w_ball_lim) &&
                      (w_ball_dy <= w_ball_lim) && (w_ball_dy >= -w_ball_lim);

  // --------------------------------------------------------------------------
  // Trail hit test, one comparator pair per history entry
  // --------------------------------------------------------------------------
  logic [4:0]       w_age [DEPTH];
  logic [DEPTH-1:0] w_hit;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [5:0]         w_age_raw;
      logic signed [10:0] w_dx;
      logic signed [10:0] w_dy;

      // age = (wr_ptr - 1 - i) mod DEPTH, computed without a divider:
      // the raw sum lies in [0, 2*DEPTH-2], so one conditional subtract wraps it.
      assign w_age_raw = 6'(r_wr_ptr) + 6'(DEPTH - 1 - gi);
      assign w_age[gi] = (w_age_raw >= 6'(DEPTH)) ? 5'(w_age_raw - 6'(DEPTH))
                                                   : 5'(w_age_raw);

      assign w_dx = $signed({1'b0, bus.DrawX}) - $signed({1'b0, r_buf_x[gi]});
      assign w_dy = $signed({1'b0, bus.DrawY}) - $signed({1'b0, r_buf_y[gi]});

      assign w_hit[gi] = (w_age[gi] < r_count) &&
                         (w_dx <= TRAIL_LIM) && (w_dx >= -TRAIL_LIM) &&
                         (w_dy <= TRAIL_LIM) && (w_dy >= -TRAIL_LIM);
    end
  endgenerate

  // Youngest hitting entry; ages are distinct so a strict minimum suffices.
  logic       w_any_hit;
  logic [4:0] w_min_age;

  always_comb begin
    w_any_hit = |w_hit;
    w_min_age = 5'(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_hit[i] && (w_age[i] < w_min_age)) begin
        w_min_age = w_age[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_is_ball   <= 1'b0;
      r_is_trail  <= 1'b0;
      r_trail_age <= 4'd0;
    end else begin
      r_is_ball   <= w_hit_ball;
      r_is_trail  <= w_any_hit;
      r_trail_age <= w_any_hit ? w_min_age[3:0] : 4'd0;
    end
  end

  assign bus.is_ball   = r_is_ball;
  assign bus.is_trail  = r_is_trail;
  assign bus.trail_age = r_trail_age;
  assign bus.count     = r_count;

endmodule
`default_nettype wire
